// File: rtl/amux_seq_pkg.sv
// Shared types and helpers for the analog-mux select sequencer.
// The optional auto-scan feature is enabled by defining AMUX_AUTO_SCAN_EN.
package amux_seq_pkg;

  // State encodings, kept explicit so the enum values are stable across tools.
  localparam logic [1:0] StEncIdle   = 2'b00;
  localparam logic [1:0] StEncBreak  = 2'b01;
  localparam logic [1:0] StEncSettle = 2'b10;
  localparam logic [1:0] StEncHold   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = StEncIdle,
    BREAK  = StEncBreak,
    SETTLE = StEncSettle,
    HOLD   = StEncHold
  } amux_seq_state_t;

  // Width needed to hold the largest interval parameter as a down-count value.
  function automatic int unsigned amux_cnt_width(input int unsigned a,
                                                 input int unsigned b,
                                                 input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/amux_seq_timer.sv
// Load / count-down interval timer. done_o is high while the count is zero;
// the count saturates at zero rather than wrapping.
module amux_seq_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load takes priority over counting; counting stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/amux_sel_sequencer.sv
// Break-before-make select sequencer for a 2:1 analog mux.
// Accepts channel requests on a valid/ready handshake, drops mux_en for a dead
// interval before moving select, then waits a settle interval before reporting
// settled with a one-cycle sample_strobe.
// Define AMUX_AUTO_SCAN_EN to add the scan_en port and dwell-based auto toggling.
module amux_sel_sequencer
  import amux_seq_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned DWELL_CYCLES  = 16
) (
  input  logic clk,
  input  logic resetb,
`ifdef AMUX_AUTO_SCAN_EN
  input  logic scan_en,
`endif
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic select,
  output logic mux_en,
  output logic settled,
  output logic sample_strobe,
  output logic busy
);

  localparam int unsigned CntW = amux_cnt_width(DEAD_CYCLES, SETTLE_CYCLES, DWELL_CYCLES);

  // Zero-length intervals would break the break-before-make guarantee.
  if (DEAD_CYCLES < 1) begin : g_bad_dead
    $error("DEAD_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
`ifdef AMUX_AUTO_SCAN_EN
  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("DWELL_CYCLES must be >= 1");
  end
`endif

  amux_seq_state_t state_q;
  logic            select_q;
  logic            sel_lat_q;
  logic            mux_en_q;
  logic            settled_q;
  logic            strobe_q;

  logic            accept;
  logic            chan_change;
  logic            scan_go;

  logic            iv_load;
  logic [CntW-1:0] iv_load_val;
  logic            iv_en;
  logic            iv_done;

  assign req_ready   = (state_q == IDLE) || (state_q == HOLD);
  assign busy        = (state_q == BREAK) || (state_q == SETTLE);
  assign accept      = req_valid && req_ready;
  assign chan_change = (state_q == IDLE) || (req_sel != select_q);

`ifdef AMUX_AUTO_SCAN_EN
  logic dw_load;
  logic dw_en;
  logic dw_done;

  // Dwell restarts on each HOLD entry and only advances while scanning is enabled.
  always_comb begin
    dw_load = (state_q == SETTLE) && iv_done;
    dw_en   = (state_q == HOLD) && scan_en;
  end

  amux_seq_timer #(
    .Width (CntW)
  ) u_dwell_timer (
    .clk_i      (clk),
    .rst_ni     (resetb),
    .load_i     (dw_load),
    .load_val_i (CntW'(DWELL_CYCLES - 1)),
    .en_i       (dw_en),
    .done_o     (dw_done)
  );

  // Self-issued toggle; an accepted external request in the same cycle wins.
  assign scan_go = (state_q == HOLD) && scan_en && dw_done && !accept;
`else
  assign scan_go = 1'b0;
`endif

  // Interval timer control: one shared counter covers the break and settle phases.
  always_comb begin
    iv_load     = 1'b0;
    iv_load_val = '0;
    iv_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          iv_load     = 1'b1;
          iv_load_val = CntW'(DEAD_CYCLES - 1);
        end
      end
      BREAK: begin
        if (iv_done) begin
          iv_load     = 1'b1;
          iv_load_val = CntW'(SETTLE_CYCLES - 1);
        end else begin
          iv_en = 1'b1;
        end
      end
      SETTLE: begin
        iv_en = !iv_done;
      end
      HOLD: begin
        if ((accept && chan_change) || scan_go) begin
          iv_load     = 1'b1;
          iv_load_val = CntW'(DEAD_CYCLES - 1);
        end
      end
      default: ;
    endcase
  end

  amux_seq_timer #(
    .Width (CntW)
  ) u_iv_timer (
    .clk_i      (clk),
    .rst_ni     (resetb),
    .load_i     (iv_load),
    .load_val_i (iv_load_val),
    .en_i       (iv_en),
    .done_o     (iv_done)
  );

  // Sequencer FSM with registered outputs; select only moves on BREAK->SETTLE.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q   <= IDLE;
      select_q  <= 1'b0;
      sel_lat_q <= 1'b0;
      mux_en_q  <= 1'b0;
      settled_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sel_lat_q <= req_sel;
            state_q   <= BREAK;
          end
        end
        BREAK: begin
          if (iv_done) begin
            select_q <= sel_lat_q;
            mux_en_q <= 1'b1;
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          if (iv_done) begin
            settled_q <= 1'b1;
            strobe_q  <= 1'b1;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (accept && !chan_change) begin
            // Same channel: path already settled, just re-issue the strobe.
            strobe_q <= 1'b1;
          end else if (accept || scan_go) begin
            sel_lat_q <= accept ? req_sel : ~select_q;
            mux_en_q  <= 1'b0;
            settled_q <= 1'b0;
            state_q   <= BREAK;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign select        = select_q;
  assign mux_en        = mux_en_q;
  assign settled       = settled_q;
  assign sample_strobe = strobe_q;

endmodule
